// File: rtl/dnnweaver_pkg.sv
// Shared dnnweaver definitions: read-info FSM state encoding,
// the d_type code that selects the stream path, and a log2 helper.
package dnnweaver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_XFER = 2'd2
    } rd_state_e;

    // d_type value routed to the stream destination; all others go to buffer
    localparam int unsigned D_TYPE_STREAM = 0;

    // ceil(log2(n)); returns 0 for n <= 1
    function automatic int C_LOG_2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/read_info_mpu_fifo.sv
// Request FIFO: first-word-fall-through, power-of-2 depth, with occupancy.
// Ports: clk/reset, push/din, pop/dout, empty, full, count.
module fifo
    import dnnweaver_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = C_LOG_2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int AW = C_LOG_2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CNT_W'(DEPTH));
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/read_info_mpu.sv
// Read-info MPU: queues read requests (size, PU, d_type) and steers each
// returned inbuf beat to the stream or buffer push of the requesting PU.
// Ports: clk/reset; rd_req + size/pu_id/d_type in, read_info_full out;
// inbuf_empty in, inbuf_pop out; per-PU stream/buffer full in and push out;
// pu_id/d_type tag of pushed beat; outstanding queue depth; sticky rd_req_err.
module read_info_mpu
    import dnnweaver_pkg::*;
#(
    parameter int NUM_PU        = 4,
    parameter int D_TYPE_W      = 2,
    parameter int RD_SIZE_W     = 20,
    parameter int RD_INFO_DEPTH = 8,
    parameter int PU_ID_W       = C_LOG_2(NUM_PU) + 1,
    parameter int CNT_W         = C_LOG_2(RD_INFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_req,
    input  logic [RD_SIZE_W-1:0] rd_req_size,
    input  logic [PU_ID_W-1:0]   rd_req_pu_id,
    input  logic [D_TYPE_W-1:0]  rd_req_d_type,
    output logic                 read_info_full,
    input  logic                 inbuf_empty,
    output logic                 inbuf_pop,
    input  logic [NUM_PU-1:0]    stream_full,
    input  logic [NUM_PU-1:0]    buffer_full,
    output logic [NUM_PU-1:0]    stream_push,
    output logic [NUM_PU-1:0]    buffer_push,
    output logic [PU_ID_W-1:0]   pu_id,
    output logic [D_TYPE_W-1:0]  d_type,
    output logic [CNT_W-1:0]     outstanding,
    output logic                 rd_req_err
);

    localparam int INFO_W = RD_SIZE_W + PU_ID_W + D_TYPE_W;

    rd_state_e r_state;
    rd_state_e w_state_nxt;

    logic [RD_SIZE_W-1:0] r_size;
    logic [RD_SIZE_W-1:0] r_cnt;
    logic [PU_ID_W-1:0]   r_act_pu;
    logic [D_TYPE_W-1:0]  r_act_dt;
    logic [PU_ID_W-1:0]   r_pu_id;
    logic [D_TYPE_W-1:0]  r_d_type;
    logic [NUM_PU-1:0]    r_stream_push;
    logic [NUM_PU-1:0]    r_buffer_push;
    logic                 r_err;

    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [INFO_W-1:0] w_fifo_din;
    logic [INFO_W-1:0] w_fifo_dout;
    logic [CNT_W-1:0]  w_fifo_count;

    logic              w_size_ok;
    logic              w_pu_ok;
    logic              w_req_err;
    logic              w_is_stream;
    logic [NUM_PU-1:0] w_pu_onehot;
    logic [NUM_PU-1:0] w_sel_full;
    logic              w_dest_full;
    logic              w_pop;
    logic              w_last;

    // Request acceptance; zero-size requests vanish without flagging
    assign w_size_ok   = (rd_req_size != '0);
    assign w_pu_ok     = (rd_req_pu_id < PU_ID_W'(NUM_PU));
    assign w_fifo_push = rd_req & w_size_ok & w_pu_ok & ~w_fifo_full;
    assign w_req_err   = rd_req & w_size_ok & (~w_pu_ok | w_fifo_full);
    assign w_fifo_din  = {rd_req_size, rd_req_pu_id, rd_req_d_type};

    fifo #(
        .WIDTH (INFO_W),
        .DEPTH (RD_INFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_fifo_push),
        .din   (w_fifo_din),
        .pop   (w_fifo_pop),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full),
        .count (w_fifo_count)
    );

    always_comb begin
        w_pu_onehot = '0;
        for (int i = 0; i < NUM_PU; i++) begin
            w_pu_onehot[i] = (r_act_pu == PU_ID_W'(i));
        end
    end

    assign w_is_stream = (r_act_dt == D_TYPE_W'(D_TYPE_STREAM));
    assign w_sel_full  = w_is_stream ? stream_full : buffer_full;
    assign w_dest_full = |(w_sel_full & w_pu_onehot);
    assign w_last      = (r_cnt == r_size - 1'b1);

    // Gated by reset so no beat is consumed while the block is being cleared
    assign w_pop = (r_state == ST_XFER) & ~reset
                 & ~inbuf_empty & ~w_dest_full;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fifo_pop  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_fifo_pop  = 1'b1;
                w_state_nxt = ST_XFER;
            end
            ST_XFER: begin
                if (w_pop && w_last)
                    w_state_nxt = w_fifo_empty ? ST_IDLE : ST_LOAD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_size        <= '0;
            r_cnt         <= '0;
            r_act_pu      <= '0;
            r_act_dt      <= '0;
            r_pu_id       <= '0;
            r_d_type      <= '0;
            r_stream_push <= '0;
            r_buffer_push <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_fifo_pop) begin
                {r_size, r_act_pu, r_act_dt} <= w_fifo_dout;
                r_cnt <= '0;
            end else if (w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_stream_push <= (w_pop && w_is_stream) ? w_pu_onehot : '0;
            r_buffer_push <= (w_pop && !w_is_stream) ? w_pu_onehot : '0;
            if (w_pop) begin
                r_pu_id  <= r_act_pu;
                r_d_type <= r_act_dt;
            end
            if (w_req_err) r_err <= 1'b1;
        end
    end

    assign read_info_full = w_fifo_full;
    assign inbuf_pop      = w_pop;
    assign stream_push    = r_stream_push;
    assign buffer_push    = r_buffer_push;
    assign pu_id          = r_pu_id;
    assign d_type         = r_d_type;
    assign outstanding    = w_fifo_count;
    assign rd_req_err     = r_err;

endmodule

// File: tb/tb_read_info_mpu.sv
// Directed bench for read_info_mpu.
// Hand-computed expectations per cycle plus a per-cycle push/pop monitor.
module tb_read_info_mpu;
  import dnnweaver_pkg::*;

  localparam int NUM_PU = 4;
  localparam int DTW = 2;
  localparam int SZW = 20;
  localparam int DEPTH = 8;
  localparam int PUW = 3;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic reset;
  logic rd_req;
  logic [SZW-1:0] rd_req_size;
  logic [PUW-1:0] rd_req_pu_id;
  logic [DTW-1:0] rd_req_d_type;
  logic read_info_full;
  logic inbuf_empty;
  logic inbuf_pop;
  logic [NUM_PU-1:0] stream_full;
  logic [NUM_PU-1:0] buffer_full;
  logic [NUM_PU-1:0] stream_push;
  logic [NUM_PU-1:0] buffer_push;
  logic [PUW-1:0] pu_id;
  logic [DTW-1:0] d_type;
  logic [CNTW-1:0] outstanding;
  logic rd_req_err;

  always #5 clk = ~clk;

  read_info_mpu #(
    .NUM_PU(NUM_PU),
    .D_TYPE_W(DTW),
    .RD_SIZE_W(SZW),
    .RD_INFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rd_req(rd_req),
    .rd_req_size(rd_req_size),
    .rd_req_pu_id(rd_req_pu_id),
    .rd_req_d_type(rd_req_d_type),
    .read_info_full(read_info_full),
    .inbuf_empty(inbuf_empty),
    .inbuf_pop(inbuf_pop),
    .stream_full(stream_full),
    .buffer_full(buffer_full),
    .stream_push(stream_push),
    .buffer_push(buffer_push),
    .pu_id(pu_id),
    .d_type(d_type),
    .outstanding(outstanding),
    .rd_req_err(rd_req_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor, sampled just before each rising edge
  logic en = 1'b0;
  logic prev_pop = 1'b0;
  int tot_pop = 0;
  int runs = 0;
  int onehot_bad = 0;
  int s_cnt [NUM_PU];
  int b_cnt [NUM_PU];

  initial begin
    wait (en);
    forever begin
      @(negedge clk);
      #4;
      check("push_lags_pop",
            32'(|{stream_push, buffer_push}), 32'(prev_pop));
      if (!$onehot0({stream_push, buffer_push})) onehot_bad++;
      for (int i = 0; i < NUM_PU; i++) begin
        s_cnt[i] += int'(stream_push[i]);
        b_cnt[i] += int'(buffer_push[i]);
      end
      if (inbuf_pop) begin
        tot_pop++;
        if (!prev_pop) runs++;
      end
      prev_pop = inbuf_pop;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic set_req(input int sz, input int pu, input int dt);
    rd_req = 1'b1;
    rd_req_size = SZW'(sz);
    rd_req_pu_id = PUW'(pu);
    rd_req_d_type = DTW'(dt);
  endtask

  int p0, r0, s0, s1, b0, b1, k;

  initial begin
    reset = 1'b1;
    rd_req = 1'b0;
    rd_req_size = '0;
    rd_req_pu_id = '0;
    rd_req_d_type = '0;
    inbuf_empty = 1'b0;
    stream_full = '0;
    buffer_full = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    en = 1'b1;
    #1;
    check("rst_outst", 32'(outstanding), 0);
    check("rst_full", 32'(read_info_full), 0);
    check("rst_err", 32'(rd_req_err), 0);
    check("rst_push", 32'({stream_push, buffer_push}), 0);
    check("rst_pu", 32'(pu_id), 0);
    check("rst_dt", 32'(d_type), 0);
    check("rst_pop", 32'(inbuf_pop), 0);
    check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

    // Single request: size 4, pu 2, stream
    p0 = tot_pop; r0 = runs; s0 = s_cnt[2];
    set_req(4, 2, 0);
    @(negedge clk); rd_req = 1'b0; #1;
    check("t1_outst_q", 32'(outstanding), 1);
    check("t1_pop_idle", 32'(inbuf_pop), 0);
    @(negedge clk); #1;
    check("t1_pop_load", 32'(inbuf_pop), 0);
    @(negedge clk); #1;
    check("t1_pop_b1", 32'(inbuf_pop), 1);
    check("t1_outst_0", 32'(outstanding), 0);
    check("t1_push_b1", 32'(stream_push), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("t1_pop_bn", 32'(inbuf_pop), 1);
      check("t1_push_bn", 32'(stream_push), 32'h4);
    end
    @(negedge clk); #1;
    check("t1_pop_end", 32'(inbuf_pop), 0);
    check("t1_push_last", 32'(stream_push), 32'h4);
    @(negedge clk); #1;
    check("t1_push_done", 32'(stream_push), 0);
    check("t1_idle", 32'(dut.r_state), 32'(ST_IDLE));
    check("t1_pops", 32'(tot_pop - p0), 4);
    check("t1_runs", 32'(runs - r0), 1);
    check("t1_spush", 32'(s_cnt[2] - s0), 4);
    check("t1_pu", 32'(pu_id), 2);
    check("t1_dt", 32'(d_type), 0);

    // Fill: one active request stalled, then 8 queued, then a 9th
    inbuf_empty = 1'b1;
    set_req(1, 0, 0);
    @(negedge clk); rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("t2_active_outst", 32'(outstanding), 0);
    check("t2_pop_empty", 32'(inbuf_pop), 0);
    for (int i = 0; i < 8; i++) begin
      set_req(1, i % 4, i % 2);
      @(negedge clk);
    end
    rd_req = 1'b0; #1;
    check("t2_full", 32'(read_info_full), 1);
    check("t2_outst8", 32'(outstanding), 8);
    check("t2_err_before", 32'(rd_req_err), 0);
    set_req(1, 1, 0);
    @(negedge clk); rd_req = 1'b0; #1;
    check("t2_err_ovf", 32'(rd_req_err), 1);
    check("t2_outst_keep", 32'(outstanding), 8);
    check("t2_full_keep", 32'(read_info_full), 1);
    p0 = tot_pop; s0 = s_cnt[0]; b0 = b_cnt[1];
    inbuf_empty = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("t2_drain_pops", 32'(tot_pop - p0), 9);
    check("t2_drain_s0", 32'(s_cnt[0] - s0), 3);
    check("t2_drain_b1", 32'(b_cnt[1] - b0), 2);
    check("t2_drain_outst", 32'(outstanding), 0);
    check("t2_drain_full", 32'(read_info_full), 0);
    check("t2_err_sticky", 32'(rd_req_err), 1);
    do_reset();
    check("t2_err_cleared", 32'(rd_req_err), 0);

    // Out-of-range PU
    p0 = tot_pop;
    set_req(1, 4, 0);
    @(negedge clk); rd_req = 1'b0; #1;
    check("tpu_err", 32'(rd_req_err), 1);
    check("tpu_outst", 32'(outstanding), 0);
    repeat (5) @(negedge clk);
    #1;
    check("tpu_no_pop", 32'(tot_pop - p0), 0);
    do_reset();

    // Buffer path with a 3-cycle stall on buffer_full[1]
    stream_full = 4'b0010;
    buffer_full = 4'b0100;
    s1 = s_cnt[1]; b1 = b_cnt[1];
    set_req(3, 1, 1);
    @(negedge clk); rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("t3_pop_b1", 32'(inbuf_pop), 1);
    @(negedge clk);
    buffer_full = 4'b0110; #1;
    check("t3_stall1", 32'(inbuf_pop), 0);
    check("t3_push_b1", 32'(buffer_push), 32'h2);
    @(negedge clk); #1;
    check("t3_stall2", 32'(inbuf_pop), 0);
    @(negedge clk); #1;
    check("t3_stall3", 32'(inbuf_pop), 0);
    @(negedge clk);
    buffer_full = 4'b0100; #1;
    check("t3_pop_b2", 32'(inbuf_pop), 1);
    @(negedge clk); #1;
    check("t3_pop_b3", 32'(inbuf_pop), 1);
    @(negedge clk); #1;
    check("t3_pop_done", 32'(inbuf_pop), 0);
    repeat (2) @(negedge clk);
    #1;
    check("t3_bpush", 32'(b_cnt[1] - b1), 3);
    check("t3_spush", 32'(s_cnt[1] - s1), 0);
    check("t3_pu", 32'(pu_id), 1);
    check("t3_dt", 32'(d_type), 1);
    stream_full = '0;
    buffer_full = '0;

    // Size 0 then size 2
    p0 = tot_pop; s0 = s_cnt[3];
    set_req(0, 3, 0);
    @(negedge clk);
    set_req(2, 3, 0);
    @(negedge clk); rd_req = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("t4_pops", 32'(tot_pop - p0), 2);
    check("t4_spush", 32'(s_cnt[3] - s0), 2);
    check("t4_err", 32'(rd_req_err), 0);
    check("t4_outst", 32'(outstanding), 0);

    // Reset after beat 2 of 5, with another request queued
    set_req(5, 0, 1);
    @(negedge clk);
    set_req(7, 3, 0);
    @(negedge clk); rd_req = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      @(negedge clk); #1;
      if (inbuf_pop) k++;
    end
    check("t5_beat2_seen", 32'(k), 2);
    @(negedge clk);
    reset = 1'b1; #1;
    check("t5_pop_in_rst", 32'(inbuf_pop), 0);
    check("t5_outst_pre", 32'(outstanding), 1);
    @(negedge clk);
    reset = 1'b0; #1;
    check("t5_no_push", 32'({stream_push, buffer_push}), 0);
    check("t5_outst", 32'(outstanding), 0);
    check("t5_idle", 32'(dut.r_state), 32'(ST_IDLE));
    check("t5_pu_clr", 32'(pu_id), 0);
    check("t5_dt_clr", 32'(d_type), 0);
    p0 = tot_pop; s0 = s_cnt[2];
    set_req(1, 2, 0);
    @(negedge clk); rd_req = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("t5_new_pops", 32'(tot_pop - p0), 1);
    check("t5_new_push", 32'(s_cnt[2] - s0), 1);
    check("t5_new_idle", 32'(dut.r_state), 32'(ST_IDLE));

    check("onehot_push", 32'(onehot_bad), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/read_info_mpu.md
READ_INFO_MPU -- requirements
Module: read_info_mpu

Interface
REQ-001 SHALL have parameter NUM_PU, default 4, meaning number of processing units (1..8).
REQ-002 SHALL have parameter D_TYPE_W, default 2, meaning data-type tag width.
REQ-003 SHALL have parameter RD_SIZE_W, default 20, meaning request size width in beats.
REQ-004 SHALL have parameter RD_INFO_DEPTH, default 8, meaning request FIFO depth (power of 2, >=2).
REQ-005 SHALL have derived PU_ID_W = C_LOG_2(NUM_PU)+1 and CNT_W = C_LOG_2(RD_INFO_DEPTH)+1.
REQ-006 SHALL have port clk, input, 1, meaning single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port rd_req, input, 1, meaning read-request enqueue strobe.
REQ-009 SHALL have ports rd_req_size, rd_req_pu_id and rd_req_d_type, inputs, RD_SIZE_W / PU_ID_W / D_TYPE_W, meaning request beats, target PU and data type.
REQ-010 SHALL have port read_info_full, output, 1, meaning request FIFO full.
REQ-011 SHALL have port inbuf_empty, input, 1, meaning the read-data buffer is empty.
REQ-012 SHALL have port inbuf_pop, output, 1, meaning pop one read-data beat.
REQ-013 SHALL have ports stream_full and buffer_full, inputs, NUM_PU each, meaning per-PU destination full.
REQ-014 SHALL have ports stream_push and buffer_push, outputs, NUM_PU each, meaning per-PU one-hot push.
REQ-015 SHALL have ports pu_id and d_type, outputs, PU_ID_W / D_TYPE_W, meaning tag of the pushed beat.
REQ-016 SHALL have port outstanding, output, CNT_W, meaning number of queued requests excluding the active one.
REQ-017 SHALL have port rd_req_err, output, 1, meaning sticky illegal-request flag.

Function
REQ-018 SHALL enqueue a request when rd_req=1, read_info_full=0, size!=0 and pu_id<NUM_PU.
REQ-019 SHALL silently drop size-0 requests and SHALL NOT set rd_req_err for them.
REQ-020 SHALL drop a request with pu_id>=NUM_PU, or one arriving while full, and SHALL set rd_req_err until reset.
REQ-021 SHALL assert read_info_full when outstanding==RD_INFO_DEPTH, and SHALL block enqueue while full even if a dequeue occurs in the same cycle.
REQ-022 SHALL implement FSM IDLE -> LOAD when the FIFO is non-empty; LOAD -> XFER after one cycle.
REQ-023 SHALL, in LOAD, dequeue the head into active size, pu_id and d_type registers and clear the beat counter.
REQ-024 SHALL route a beat to stream when active d_type==0 and to buffer otherwise; dest_full is the selected full bit at the active pu_id.
REQ-025 SHALL assert inbuf_pop combinationally, only in XFER, when inbuf_empty=0 and dest_full=0.
REQ-026 SHALL assert stream_push/buffer_push one cycle after each inbuf_pop, one-hot at the active pu_id, with pu_id and d_type registered alongside.
REQ-027 SHALL increment the beat counter per pop, and on the pop where counter==size-1 go XFER -> LOAD if the FIFO is non-empty, else -> IDLE.
REQ-028 SHALL make back-to-back requests gap-free except for the single LOAD cycle.
REQ-029 SHALL make a full size of 2^RD_SIZE_W-1 beats legal with no counter wrap.

Reset
REQ-030 SHALL, on reset, set FSM=IDLE and clear FIFO pointers, counter, outstanding, rd_req_err, inbuf_pop, all push bits, pu_id and d_type to 0.
REQ-031 SHALL have reset mid-transfer abandon the active and queued requests with no push in the following cycle.

Structure
REQ-032 SHALL place FSM state encodings and the stream/buffer d_type code in the shared dnnweaver package.
REQ-033 SHALL instantiate the request store as a single sub-module, fifo, of width RD_SIZE_W+PU_ID_W+D_TYPE_W.

Verification
REQ-034 SHALL cover a single request of size=4, pu=2, d_type=0 with inbuf never empty: 4 pops on consecutive cycles, stream_push=4'b0100 lagging one cycle, then IDLE.
REQ-035 SHALL cover 8 requests enqueued with inbuf empty: read_info_full=1 after 8, a 9th rd_req sets rd_req_err=1 and outstanding stays 8.
REQ-036 SHALL cover size=3, d_type=1, pu=1 with buffer_full[1] high for cycles 2-4: inbuf_pop=0 throughout the stall, then 3 buffer_push=4'b0010 total.
REQ-037 SHALL cover rd_req with size=0 then size=2: exactly 2 pops and rd_req_err=0.
REQ-038 SHALL cover reset asserted after beat 2 of 5: next cycle no push, outstanding=0, FSM IDLE, and a new request of size=1 completes normally.
